// File: rtl/ps2_kbd_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 keyboard
// scan-code sequencer and its event FIFO.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;

  localparam int EVT_W        = 10;
  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_CODE_W   = 8;
  localparam int EVT_BRK_BIT  = 8;
  localparam int EVT_EXT_BIT  = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  // Keyboard reports buffer overrun / internal error with these two bytes.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO. A push while full is accepted when a
// pop happens in the same cycle (pop is taken first).
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok_s;
  logic             push_ok_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into single key events,
// queues them in a FWFT FIFO and gates the receiver while the queue is full.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  input  logic       key_rd,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  kbd_state_e       state_q, state_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             rx_en_q, rx_en_d;
  logic             ovf_q, ovf_d;
  logic             tick_s;
  logic             tmo_s;
  logic             push_s;
  kbd_evt_t         evt_s;
  logic [EVT_W-1:0] head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             drop_s;

  assign tick_s = rx_done_tick & enable;
  assign tmo_s  = (state_q != ST_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A tick on the expiry cycle is still decoded in the prefix state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_PFX_EXT)      state_d = ST_GOT_E0;
          else if (rx_data == PS2_PFX_BRK) state_d = ST_GOT_F0;
          else                             state_d = ST_IDLE;
        end
        ST_GOT_E0: begin
          if (rx_data == PS2_PFX_BRK)      state_d = ST_GOT_E0F0;
          else if (rx_data == PS2_PFX_EXT) state_d = ST_GOT_E0;
          else                             state_d = ST_IDLE;
        end
        ST_GOT_F0, ST_GOT_E0F0: begin
          if (rx_data == PS2_PFX_EXT)      state_d = ST_GOT_E0;
          else if (rx_data == PS2_PFX_BRK) state_d = state_q;
          else                             state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    push_s   = 1'b0;
    evt_s    = '0;
    evt_s.code = rx_data;
    if (tick_s && !is_prefix(rx_data)) begin
      case (state_q)
        ST_IDLE: begin
          push_s = ~is_err_byte(rx_data);
        end
        ST_GOT_E0: begin
          push_s    = 1'b1;
          evt_s.ext = 1'b1;
        end
        ST_GOT_F0: begin
          push_s    = 1'b1;
          evt_s.brk = 1'b1;
        end
        ST_GOT_E0F0: begin
          push_s    = 1'b1;
          evt_s.ext = 1'b1;
          evt_s.brk = 1'b1;
        end
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!enable || tick_s || state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Full implies non-empty, so key_rd alone means the pop frees a slot.
  assign drop_s = push_s & fifo_full_s & ~key_rd;

  always_comb begin
    rx_en_d = enable & ~fifo_full_s;
    ovf_d   = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_en_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rx_en_q <= rx_en_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .wdata_i (evt_s),
    .pop_i   (key_rd),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign rx_en     = rx_en_q;
  assign overflow  = ovf_q;
  assign key_valid = ~fifo_empty_s;
  assign key_code  = fifo_empty_s ? 8'h00 : head_s[EVT_CODE_LSB +: EVT_CODE_W];
  assign key_ext   = ~fifo_empty_s & head_s[EVT_EXT_BIT];
  assign key_brk   = ~fifo_empty_s & head_s[EVT_BRK_BIT];

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: expected events are queued as bytes are
// driven and compared against the FIFO head as it is popped.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_rd;
  logic       overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] sb[$];

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_brk      (key_brk),
    .key_rd       (key_rd),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
    key_rd = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_en, key_valid, key_code, key_ext, key_brk, overflow} !== 13'h0)
      $display("FAIL reset_outputs: got %b want 0", {rx_en, key_valid, key_code, key_ext, key_brk, overflow});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    n_checks++;
    if (rx_en !== 1'b0) $display("FAIL rx_en_before_enable: got %b want 0", rx_en);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rx_en !== 1'b1) $display("FAIL rx_en_after_enable: got %b want 1", rx_en);
    else n_pass++;
  endtask

  task automatic test_plain_make();
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C);
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL plain_make: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL plain_make_empty: got %b want 0", key_valid);
    else n_pass++;
  endtask

  task automatic test_ext_break();
    send_byte(8'hE0);
    send_byte(8'hF0);
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL ext_break_prefix: got valid %b want 0", key_valid);
    else n_pass++;
    sb.push_back({2'b11, 8'h75});
    send_byte(8'h75);
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL ext_break: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL ext_break_single: got %b want 0", key_valid);
    else n_pass++;
  endtask

  // Gap of TMO idle cycles expires the prefix; TMO-1 lets the tick win.
  task automatic test_timeout();
    for (int g = 0; g < 2; g++) begin
      send_byte(8'hF0);
      repeat ((g == 0) ? TMO - 1 : TMO - 2) @(negedge clk);
      sb.push_back({1'b0, (g == 0) ? 1'b0 : 1'b1, 8'h1C});
      send_byte(8'h1C);
      while (sb.size() > 0) begin
        logic [9:0] exp = sb.pop_front();
        n_checks++;
        if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
          $display("FAIL timeout_gap%0d: got v%b e%b b%b %h want %h", g, key_valid, key_ext, key_brk, key_code, exp);
        else n_pass++;
        pop_one();
      end
    end
  endtask

  task automatic test_error_resync();
    send_byte(8'h00);
    send_byte(8'hFF);
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL error_bytes: got valid %b want 0", key_valid);
    else n_pass++;
    send_byte(8'hF0);
    send_byte(8'hE0);
    sb.push_back({2'b10, 8'h6B});
    send_byte(8'h6B);
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL resync: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] c = 8'h11 + 8'(i);
      sb.push_back({2'b00, c});
      send_byte(c);
    end
    @(negedge clk);
    n_checks++;
    if (rx_en !== 1'b0) $display("FAIL full_rx_en: got %b want 0", rx_en);
    else n_pass++;
    send_byte(8'h15);
    n_checks++;
    if (overflow !== 1'b1 || key_code !== 8'h11)
      $display("FAIL drop_when_full: got ovf %b code %h want 1 11", overflow, key_code);
    else n_pass++;
    @(negedge clk);
    rx_done_tick = 1'b1; rx_data = 8'h16; key_rd = 1'b1;
    void'(sb.pop_front());
    sb.push_back({2'b00, 8'h16});
    @(negedge clk);
    rx_done_tick = 1'b0; key_rd = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || key_code !== 8'h12)
      $display("FAIL push_with_pop: got ovf %b code %h want 1 12", overflow, key_code);
    else n_pass++;
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b want 0", overflow);
    else n_pass++;
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL overflow_drain: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (key_valid !== 1'b0 || rx_en !== 1'b1)
      $display("FAIL overflow_after: got valid %b rx_en %b want 0 1", key_valid, rx_en);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5] = '{8'h21, 8'hE0, 8'h22, 8'hF0, 8'h23};
    sb.push_back({2'b00, 8'h21});
    sb.push_back({2'b10, 8'h22});
    sb.push_back({2'b01, 8'h23});
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_done_tick = 1'b1;
      rx_data      = bytes[i];
      @(negedge clk);
    end
    rx_done_tick = 1'b0;
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL back_to_back: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_enable_gating();
    send_byte(8'hE0);
    @(negedge clk); enable = 1'b0;
    rx_done_tick = 1'b1; rx_data = 8'h44;
    @(negedge clk); rx_done_tick = 1'b0; enable = 1'b1;
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL disabled_tick: got valid %b want 0", key_valid);
    else n_pass++;
    sb.push_back({2'b00, 8'h33});
    send_byte(8'h33);
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL enable_gating: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_reset_mid();
    sb.push_back({2'b00, 8'h41});
    send_byte(8'h41);
    sb.push_back({2'b00, 8'h42});
    send_byte(8'h42);
    send_byte(8'hE0);
    n_checks++;
    if (key_valid !== 1'b1) $display("FAIL reset_mid_pre: got valid %b want 1", key_valid);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    sb.delete();
    n_checks++;
    if ({rx_en, key_valid, key_code, key_ext, key_brk, overflow} !== 13'h0)
      $display("FAIL reset_mid_async: got %b want 0", {rx_en, key_valid, key_code, key_ext, key_brk, overflow});
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    sb.push_back({2'b00, 8'h74});
    send_byte(8'h74);
    while (sb.size() > 0) begin
      logic [9:0] exp = sb.pop_front();
      n_checks++;
      if ({key_valid, key_ext, key_brk, key_code} !== {1'b1, exp})
        $display("FAIL reset_mid_after: got v%b e%b b%b %h want %h", key_valid, key_ext, key_brk, key_code, exp);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL reset_mid_empty: got %b want 0", key_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_plain_make();
    test_ext_break();
    test_timeout();
    test_error_resync();
    test_overflow();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Scan-code sequencer that sits directly behind `ps2_rx` and ahead of the keyboard consumer logic. Gates the receiver with `rx_en` and interprets the byte stream (prefixes `E0h` extended, `F0h` break). Emits one complete key event per make/break code, with extended and break flags, into a small first-word-fall-through event FIFO. Also recovers from truncated prefix sequences with a timeout.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2, ≥2.
- `TIMEOUT_CYC`, 50000: clk cycles a prefix state may wait for its next byte (1 ms at 50 MHz).
- `clk`  in  1  system clock, single domain.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  controller enable; low = receiver gated off, no new events.
- `rx_done_tick`  in  1  one-cycle strobe from `ps2_rx`; `rx_data` is valid with it.
- `rx_data`  in  8  received byte (`ps2_rx.dout`).
- `rx_en`  out  1  receiver enable to `ps2_rx.rx_en`.
- `key_valid`  out  1  FIFO not empty; head event is presented.
- `key_code`  out  8  head event scan code.
- `key_ext`  out  1  head event was `E0`-prefixed.
- `key_brk`  out  1  head event is a break (release).
- `key_rd`  in  1  pop head event; ignored when `key_valid`=0.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- **Decoder FSM**, states `IDLE`, `GOT_E0`, `GOT_F0`, `GOT_E0F0`. It advances only on `rx_done_tick`.
  - `IDLE`:
    - `E0` → `GOT_E0`.
    - `F0` → `GOT_F0`.
    - `00h` / `FFh` (keyboard error/overrun) → dropped, stay.
    - Any other byte → push {ext=0, brk=0, code}.
  - `GOT_E0`:
    - `F0` → `GOT_E0F0`.
    - `E0` → stay.
    - Other → push {1,0,code}, → `IDLE`.
  - `GOT_F0`:
    - `E0` → `GOT_E0` (resync).
    - `F0` → stay.
    - Other → push {0,1,code}, → `IDLE`.
  - `GOT_E0F0`:
    - `E0` → `GOT_E0`.
    - `F0` → stay.
    - Other → push {1,1,code}, → `IDLE`.
- **Prefix timeout:** a counter runs in any non-`IDLE` state and restarts on each `rx_done_tick`. When it reaches `TIMEOUT_CYC`, the FSM goes to `IDLE` with no push.
- **`enable` low:** the FSM forces `IDLE` and the timeout counter clears. The FIFO contents are kept and popping continues.
- **Receiver gating:** `rx_en` = `enable` & ~FIFO full, registered.
- **Event FIFO:**
  - Each entry is 10 bits {ext, brk, code}.
  - The head is shown on `key_*` whenever `key_valid`=1.
- **Push while full:**
  - If `key_rd` is also asserted that cycle, the pop is taken first and the push is accepted.
  - Otherwise the event is dropped and `overflow` is set.
  - This case arises for a frame already in flight when `rx_en` fell.
- **`overflow`:** set has priority over `ovf_clr` in the same cycle.
- **Reset values:** `rx_en`=0, `key_valid`=0, `key_code`=00h, `key_ext`=0, `key_brk`=0, `overflow`=0, FSM=`IDLE`, FIFO empty, timeout counter 0.
- **Reset mid-sequence:** the partial prefix and all queued events are discarded.

## Timing
- `rx_done_tick` at edge N → `key_valid`=1 and the event on `key_*` after edge N+1. Latency is 1 cycle into an empty FIFO.
- `key_rd` at edge N → the next entry (or `key_valid`=0) after edge N.
- `rx_en` follows `enable`/full with 1 cycle of latency. After reset, `rx_en` first rises 1 cycle after `enable`=1.
- Throughput: 1 byte per cycle into the FSM. This far exceeds the PS/2 rate of about 1 byte per 1.1 ms.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the last tick. A tick arriving on the expiry cycle is processed in the prefix state; the tick wins.

## Structure
- Shared package `ps2_kbd_pkg`:
  - Constants `PS2_PFX_EXT`=E0h, `PS2_PFX_BRK`=F0h, `PS2_ERR0`=00h, `PS2_ERR1`=FFh.
  - FSM state encoding (2 bits).
  - Event width 10 and field offsets.
- One sub-module, `ps2_evt_fifo`:
  - Parameterized width/depth, FWFT, pointer wrap via an extra MSB.
  - Outputs full/empty, push/pop.
- The FSM, timeout counter, `rx_en` register and overflow flag live in `ps2_kbd_ctrl`.

## Test plan
- **Plain make:** after reset, `enable`=1, tick 1Ch → after 1 cycle `key_valid`=1, code 1Ch, ext=0, brk=0. `key_rd` → `key_valid`=0.
- **Extended break:** ticks E0, F0, 75h → exactly one event {ext=1, brk=1, 75h}. No event for the prefixes.
- **Timeout:** tick F0, idle `TIMEOUT_CYC` cycles, tick 1Ch → event {0,0,1Ch}, not a break. Repeat with the gap `TIMEOUT_CYC`-1 → {0,1,1Ch}.
- **Full / overflow:** `FIFO_DEPTH`=4, no reads:
  - 4 makes → `rx_en`=0 one cycle after the 4th.
  - 5th tick → dropped, `overflow`=1, `key_code` still the 1st code.
  - Tick with `key_rd` → accepted, `overflow` unchanged.
  - `ovf_clr` → 0.
- **Error bytes / resync:** ticks 00h, FFh → no events. Ticks F0, E0, 6Bh → {1,0,6Bh}.
- **Reset mid-operation:** 2 queued events plus a pending E0; assert `reset` asynchronously → all outputs at reset values immediately. After release, tick 74h → {0,0,74h}.
